// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: opcodes, writeback/branch enums and the decoded control bundle
package rv32_ctrl_pkg;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC} wb_src_e;
    typedef enum logic [1:0] {BRA_NONE, BRA_JMP, BRA_CMP, BRA_ALU} bra_mode_e;
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        wb_src_e     wb_src;
        logic        alu_imm_b;
        logic        alu_pc_a;
        logic        alu_alt;
        logic [2:0]  alu_op;
        logic [31:0] imm;
        logic        cmp_z;
        logic        cmp_inv;
        bra_mode_e   bra_mode;
        logic        mem_en;
        logic        mem_we;
        logic [2:0]  mem_func;
        logic        muldiv;
        logic        illegal;
        logic        brk;
    } ctrl_t;
endpackage

// File: rtl/rv32_imm_gen.sv
// rv32_imm_gen: sign-extended I/S/B/U/J immediate chosen by opcode (i_instr in, o_imm out)
module rv32_imm_gen
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm
);
    logic [6:0] w_opc;
    assign w_opc = i_instr[6:0];
    always_comb
        o_imm = (w_opc == OPC_LUI || w_opc == OPC_AUIPC) ? {i_instr[31:12], 12'b0} :
                (w_opc == OPC_JAL) ? {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0} :
                (w_opc == OPC_BRANCH) ? {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0} :
                (w_opc == OPC_STORE) ? {{21{i_instr[31]}}, i_instr[30:25], i_instr[11:7]} :
                (w_opc == OPC_JALR || w_opc == OPC_LOAD || w_opc == OPC_IMM) ? {{21{i_instr[31]}}, i_instr[30:20]} :
                32'b0;
endmodule

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage: registered RV32 decode stage; fetch handshake in, control bundle out, halts on traps
module rv32_decode_stage
    import rv32_ctrl_pkg::*;
#(
    parameter bit ENABLE_M   = 1'b1,
    parameter int REG_ADDR_W = 5,
    parameter int PC_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  flush,
    input  logic                  resume,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [1:0]            wb_src,
    output logic                  alu_imm_b,
    output logic                  alu_pc_a,
    output logic                  alu_alt,
    output logic [2:0]            alu_op,
    output logic [31:0]           imm,
    output logic                  cmp_z,
    output logic                  cmp_inv,
    output logic [1:0]            bra_mode,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [2:0]            mem_func,
    output logic                  muldiv,
    output logic                  illegal,
    output logic                  brk,
    output logic                  halted
);
    ctrl_t           w_dec;
    ctrl_t           r_ctrl;
    logic            w_bad;
    logic            w_accept;
    logic            r_valid;
    logic            r_halted;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     w_imm;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    assign w_f3 = in_instr[14:12];
    assign w_f7 = in_instr[31:25];
    rv32_imm_gen u_imm (.i_instr(in_instr), .o_imm(w_imm));
    always_comb begin
        w_dec = '0;
        w_bad = 1'b0;
        w_dec.imm = w_imm;
        case (in_instr[6:0])
            OPC_LUI, OPC_AUIPC: begin
                w_dec.wb_src = WB_ALU;
                w_dec.rd = in_instr[11:7];
                w_dec.alu_pc_a = in_instr[6:0] == OPC_AUIPC;
            end
            OPC_JAL: begin
                w_dec.wb_src = WB_PC;
                w_dec.bra_mode = BRA_JMP;
                w_dec.rd = in_instr[11:7];
            end
            OPC_JALR: begin
                w_bad = w_f3 != 3'b000;
                w_dec.wb_src = WB_PC;
                w_dec.bra_mode = BRA_ALU;
                w_dec.alu_imm_b = 1'b1;
                w_dec.rd = in_instr[11:7];
                w_dec.rs1 = in_instr[19:15];
            end
            OPC_BRANCH: begin
                w_bad = w_f3[2:1] == 2'b01;
                w_dec.bra_mode = BRA_CMP;
                w_dec.cmp_z = ~in_instr[14];
                w_dec.cmp_inv = in_instr[12];
                w_dec.rs1 = in_instr[19:15];
                w_dec.rs2 = in_instr[24:20];
            end
            OPC_LOAD: begin
                // rejects 011, 110 and 111
                w_bad = w_f3[1:0] == 2'b11 || w_f3[2:1] == 2'b11;
                w_dec.wb_src = WB_MEM;
                w_dec.mem_en = 1'b1;
                w_dec.mem_func = w_f3;
                w_dec.rd = in_instr[11:7];
                w_dec.rs1 = in_instr[19:15];
            end
            OPC_STORE: begin
                w_bad = w_f3[2] || w_f3[1:0] == 2'b11;
                w_dec.mem_en = 1'b1;
                w_dec.mem_we = 1'b1;
                w_dec.mem_func = w_f3;
                w_dec.rs1 = in_instr[19:15];
                w_dec.rs2 = in_instr[24:20];
            end
            OPC_IMM: begin
                w_bad = (w_f3 == 3'b001 && w_f7 != 7'h00) ||
                        (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
                w_dec.wb_src = WB_ALU;
                w_dec.alu_imm_b = 1'b1;
                w_dec.alu_op = w_f3;
                w_dec.alu_alt = w_f3 == 3'b101 && in_instr[30];
                w_dec.rd = in_instr[11:7];
                w_dec.rs1 = in_instr[19:15];
            end
            OPC_OP: begin
                w_bad = !(w_f7 == 7'h00 ||
                          (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)) ||
                          (w_f7 == 7'h01 && ENABLE_M));
                w_dec.wb_src = WB_ALU;
                w_dec.alu_op = w_f3;
                w_dec.alu_alt = w_f7 == 7'h20;
                w_dec.muldiv = w_f7 == 7'h01;
                w_dec.rd = in_instr[11:7];
                w_dec.rs1 = in_instr[19:15];
                w_dec.rs2 = in_instr[24:20];
            end
            OPC_SYSTEM: begin
                w_dec.brk = in_instr == INSTR_EBREAK;
                w_bad = !w_dec.brk;
            end
            default: w_bad = 1'b1;
        endcase
        // unused indices are already 0, so only live indices can trip the RV32E limit
        if (REG_ADDR_W < 5 && (w_dec.rs1[4] || w_dec.rs2[4] || w_dec.rd[4]))
            w_bad = 1'b1;
        if (w_bad) begin
            w_dec = '0;
            w_dec.illegal = 1'b1;
        end
    end
    assign in_ready = !rst && !r_halted && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready && !flush;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_halted <= 1'b0;
            r_pc <= '0;
            r_ctrl <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_halted <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_halted <= w_dec.illegal || w_dec.brk;
            r_pc <= in_pc;
            r_ctrl <= w_dec;
        end else begin
            r_valid <= r_valid && !out_ready;
            r_halted <= r_halted && !resume;
        end
    end
    assign out_valid = r_valid;
    assign halted = r_halted;
    assign out_pc = r_pc;
    assign rs1 = r_ctrl.rs1[REG_ADDR_W-1:0];
    assign rs2 = r_ctrl.rs2[REG_ADDR_W-1:0];
    assign rd = r_ctrl.rd[REG_ADDR_W-1:0];
    assign wb_src = r_ctrl.wb_src;
    assign alu_imm_b = r_ctrl.alu_imm_b;
    assign alu_pc_a = r_ctrl.alu_pc_a;
    assign alu_alt = r_ctrl.alu_alt;
    assign alu_op = r_ctrl.alu_op;
    assign imm = r_ctrl.imm;
    assign cmp_z = r_ctrl.cmp_z;
    assign cmp_inv = r_ctrl.cmp_inv;
    assign bra_mode = r_ctrl.bra_mode;
    assign mem_en = r_ctrl.mem_en;
    assign mem_we = r_ctrl.mem_we;
    assign mem_func = r_ctrl.mem_func;
    assign muldiv = r_ctrl.muldiv;
    assign illegal = r_ctrl.illegal;
    assign brk = r_ctrl.brk;
endmodule

// File: tb/tb_rv32_decode_stage.sv
// tb_rv32_decode_stage: RV32I+M and RV32E-without-M stages driven in parallel against a reference decoder
module tb_rv32_decode_stage;
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic        imm_b;
        logic        pc_a;
        logic        alt;
        logic [2:0]  op;
        logic [31:0] imm;
        logic        cz;
        logic        ci;
        logic [1:0]  bra;
        logic        men;
        logic        mwe;
        logic [2:0]  mf;
        logic        md;
        logic        ill;
        logic        brk;
    } exp_t;

    localparam logic [7:0] LOAD_OK = 8'b0011_0111;
    localparam logic [69:0] OPS = {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        resume;
    logic        out_ready;

    exp_t        got [2];
    logic        got_rdy [2];
    logic        got_vld [2];
    logic        got_hlt [2];
    logic [31:0] got_pc [2];

    bit          m_valid [2];
    bit          m_halt [2];
    exp_t        m_bund [2];
    logic [31:0] m_pc [2];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int RW = (g == 0) ? 5 : 4;
        logic [RW-1:0] rs1, rs2, rd;
        logic [1:0]    wb_src, bra_mode;
        logic [2:0]    alu_op, mem_func;
        logic [31:0]   imm, out_pc;
        logic          in_ready, out_valid, alu_imm_b, alu_pc_a, alu_alt, cmp_z, cmp_inv;
        logic          mem_en, mem_we, muldiv, illegal, brk, halted;
        rv32_decode_stage #(.ENABLE_M(g == 0), .REG_ADDR_W(RW), .PC_W(32)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .resume(resume),
            .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
            .rs1(rs1), .rs2(rs2), .rd(rd), .wb_src(wb_src),
            .alu_imm_b(alu_imm_b), .alu_pc_a(alu_pc_a), .alu_alt(alu_alt), .alu_op(alu_op),
            .imm(imm), .cmp_z(cmp_z), .cmp_inv(cmp_inv), .bra_mode(bra_mode),
            .mem_en(mem_en), .mem_we(mem_we), .mem_func(mem_func), .muldiv(muldiv),
            .illegal(illegal), .brk(brk), .halted(halted)
        );
        assign got[g] = '{rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'(rd), wb: wb_src,
                          imm_b: alu_imm_b, pc_a: alu_pc_a, alt: alu_alt, op: alu_op,
                          imm: imm, cz: cmp_z, ci: cmp_inv, bra: bra_mode,
                          men: mem_en, mwe: mem_we, mf: mem_func, md: muldiv,
                          ill: illegal, brk: brk};
        assign got_rdy[g] = in_ready;
        assign got_vld[g] = out_valid;
        assign got_hlt[g] = halted;
        assign got_pc[g] = out_pc;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t decode_ref(input logic [31:0] x, input bit m_en, input bit rve);
        exp_t e = '0;
        bit ok = 1'b1;
        logic [2:0] f3 = x[14:12];
        logic [6:0] f7 = x[31:25];
        case (x[6:0])
            7'h37, 7'h17: begin
                e.wb = 2'd1;
                e.rd = x[11:7];
                e.imm = {x[31:12], 12'h000};
                e.pc_a = x[6:0] == 7'h17;
            end
            7'h6F: begin
                e.wb = 2'd3;
                e.bra = 2'd1;
                e.rd = x[11:7];
                e.imm = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            end
            7'h67: begin
                ok = f3 == 0;
                e.wb = 2'd3;
                e.bra = 2'd3;
                e.imm_b = 1'b1;
                e.rd = x[11:7];
                e.rs1 = x[19:15];
                e.imm = 32'($signed(x[31:20]));
            end
            7'h63: begin
                ok = !(f3 == 2 || f3 == 3);
                e.bra = 2'd2;
                e.cz = !x[14];
                e.ci = x[12];
                e.rs1 = x[19:15];
                e.rs2 = x[24:20];
                e.imm = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            end
            7'h03: begin
                ok = LOAD_OK[f3];
                e.wb = 2'd2;
                e.men = 1'b1;
                e.mf = f3;
                e.rd = x[11:7];
                e.rs1 = x[19:15];
                e.imm = 32'($signed(x[31:20]));
            end
            7'h23: begin
                ok = f3 < 3;
                e.men = 1'b1;
                e.mwe = 1'b1;
                e.mf = f3;
                e.rs1 = x[19:15];
                e.rs2 = x[24:20];
                e.imm = 32'($signed({x[31:25], x[11:7]}));
            end
            7'h13: begin
                e.wb = 2'd1;
                e.imm_b = 1'b1;
                e.op = f3;
                e.rd = x[11:7];
                e.rs1 = x[19:15];
                e.imm = 32'($signed(x[31:20]));
                if (f3 == 1) ok = f7 == 0;
                if (f3 == 5) begin
                    ok = f7 == 0 || f7 == 32;
                    e.alt = x[30];
                end
            end
            7'h33: begin
                e.wb = 2'd1;
                e.op = f3;
                e.rd = x[11:7];
                e.rs1 = x[19:15];
                e.rs2 = x[24:20];
                if (f7 == 32) begin
                    ok = f3 == 0 || f3 == 5;
                    e.alt = 1'b1;
                end else if (f7 == 1) begin
                    ok = m_en;
                    e.md = 1'b1;
                end else if (f7 != 0) ok = 1'b0;
            end
            7'h73: begin
                ok = x == 32'h0010_0073;
                e.brk = 1'b1;
            end
            default: ok = 1'b0;
        endcase
        if (rve && (e.rs1 > 15 || e.rs2 > 15 || e.rd > 15)) ok = 1'b0;
        if (!ok) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        int k = $urandom_range(0, 11);
        if (k >= 10) return r;
        r[6:0] = OPS[k*7 +: 7];
        if ($urandom_range(0, 1) == 1) begin
            r[11] = 1'b0;
            r[19] = 1'b0;
            r[24] = 1'b0;
        end
        if (r[6:0] == 7'h33) r[31:25] = ($urandom_range(0, 2) == 0) ? 7'h00 : ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h01;
        if (r[6:0] == 7'h13 && r[13:12] == 2'b01) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h00 : 7'h20;
        if (r[6:0] == 7'h73 && $urandom_range(0, 2) != 0) r = 32'h0010_0073;
        return r;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl, input logic res);
        logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
        bit rdy, acc;
        in_valid = v;
        in_instr = ins;
        in_pc = pc;
        out_ready = ordy;
        flush = fl;
        resume = res;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdy = !m_halt[k] && (!m_valid[k] || ordy);
            check($sformatf("in_ready%0d", k), got_rdy[k], rdy);
            acc = v && rdy && !fl;
            if (fl) begin
                m_valid[k] = 1'b0;
                m_halt[k] = 1'b0;
            end else if (acc) begin
                m_valid[k] = 1'b1;
                m_bund[k] = decode_ref(ins, k == 0, k == 1);
                m_pc[k] = pc;
                m_halt[k] = m_bund[k].ill || m_bund[k].brk;
            end else begin
                if (ordy) m_valid[k] = 1'b0;
                if (res) m_halt[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid%0d", k), got_vld[k], m_valid[k]);
            check($sformatf("halted%0d", k), got_hlt[k], m_halt[k]);
            check($sformatf("out_pc%0d", k), got_pc[k], m_pc[k]);
            check($sformatf("bundle%0d", k), got[k], m_bund[k]);
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0;
            m_halt[k] = 1'b0;
            m_bund[k] = '0;
            m_pc[k] = '0;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        flush = 1'b0;
        resume = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_ready%0d", k), got_rdy[k], 1'b0);
            check($sformatf("rst_valid%0d", k), got_vld[k], 1'b0);
            check($sformatf("rst_bundle%0d", k), got[k], '0);
        end
        rst = 1'b0;
        step(1, 32'h0050_0093, 1, 0, 0);
        check("addi_rd", got[0].rd, 1);
        check("addi_imm", got[0].imm, 5);
        check("addi_wb", got[0].wb, 1);
        check("addi_immb", got[0].imm_b, 1);
        step(1, 32'h1234_5137, 1, 0, 0);
        repeat (3) step(1, 32'h0050_0093, 0, 0, 0);
        check("lui_held_imm", got[0].imm, 32'h1234_5000);
        check("lui_held_rdy", got_rdy[0], 0);
        step(1, 32'h0050_0093, 1, 0, 0);
        check("addi_after_lui", got[0].imm, 5);
        step(0, 0, 1, 0, 0);
        step(1, 32'h0220_81B3, 1, 0, 0);
        check("mul_md", got[0].md, 1);
        check("mul_rd", got[0].rd, 3);
        check("nom_illegal", got[1].ill, 1);
        check("nom_halt", got_hlt[1], 1);
        step(0, 0, 1, 0, 1);
        step(1, 32'h0010_0073, 1, 0, 0);
        check("ebreak_brk", got[0].brk, 1);
        check("ebreak_halt", got_hlt[0], 1);
        repeat (2) step(1, 32'h0050_0093, 1, 0, 0);
        step(1, 32'h0050_0093, 1, 0, 1);
        step(1, 32'h0050_0093, 1, 0, 0);
        check("resume_accept", got[0].imm, 5);
        step(1, 32'hFFFF_FFFF, 1, 0, 0);
        check("ones_illegal", got[0].ill, 1);
        check("ones_wb", got[0].wb, 0);
        step(0, 0, 1, 0, 1);
        step(1, 32'h0100_0093, 1, 0, 0);
        check("rve_imm16_legal", got[1].ill, 0);
        step(1, 32'h0000_0813, 1, 0, 0);
        check("rve_x16_illegal", got[1].ill, 1);
        check("rvi_x16_rd", got[0].rd, 16);
        step(0, 0, 1, 0, 1);
        step(1, 32'h0050_0093, 0, 0, 0);
        step(1, 32'h1234_5137, 1, 1, 1);
        check("flush_valid", got_vld[0], 0);
        check("flush_kept_rd", got[0].rd, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        step(0, 0, 1, 1, 0);
        step(1, 32'h0050_0093, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("arst_valid%0d", k), got_vld[k], 1'b0);
            check($sformatf("arst_ready%0d", k), got_rdy[k], 1'b0);
            check($sformatf("arst_pc%0d", k), got_pc[k], '0);
            check($sformatf("arst_bundle%0d", k), got[k], '0);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 32'h0050_0093, 1, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
